sprite_line_buffer: RTL and testbench

Double-buffered sprite line buffer that sits directly downstream of the sprite renderer. It serves the renderer's read-modify-write port on the "render" bank while the composer reads the finished previous line from the "display" bank. The display bank is cleared as it is consumed, so every new render line starts fully transparent (all 16-bit entries 0). Banks swap on line_render_start, the same strobe that restarts the renderer.

---
 rtl/sprlb_pkg.sv | 27 ++
 rtl/sprlb_bank.sv | 36 +++
 rtl/sprite_line_buffer.sv | 162 ++++++++++++++++
 tb/tb_sprite_line_buffer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprlb_pkg.sv
// Shared sizes, entry layout and FSM encoding for the sprite line buffer.
// Optional build macro SPRLB_WRITE_MASK_EN restricts the buffer to the visible span.
package sprlb_pkg;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned VISIBLE = 640;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] VIS_IDX  = ADDR_W'(VISIBLE);

  // Entry layout: {collision[3:0], 2'b0, z[1:0], color[7:0]}
  localparam int unsigned COLL_MSB  = 15;
  localparam int unsigned COLL_LSB  = 12;
  localparam int unsigned Z_MSB     = 9;
  localparam int unsigned Z_LSB     = 8;
  localparam int unsigned COLOR_MSB = 7;
  localparam int unsigned COLOR_LSB = 0;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StSweep
  } state_e;

endpackage

// File: rtl/sprlb_bank.sv
// One DEPTH x DATA_W line bank: registered read port, single write port,
// write-first when both ports address the same entry in a cycle.
module sprlb_bank
  import sprlb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q <= '0;
    end else if (wr_en_i && (wr_idx_i == rd_idx_i)) begin
      rd_q <= wr_data_i;
    end else begin
      rd_q <= mem_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/sprite_line_buffer.sv
// Double-buffered sprite line buffer: render bank RMW port, clear-on-read display bank.
// Build macro SPRLB_WRITE_MASK_EN drops off-screen writes and removes the tail sweep.
module sprite_line_buffer
  import sprlb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              line_render_start,
  input  logic [ADDR_W-1:0] render_rdidx,
  output logic [DATA_W-1:0] render_rddata,
  input  logic [ADDR_W-1:0] render_wridx,
  input  logic [DATA_W-1:0] render_wrdata,
  input  logic              render_wren,
  input  logic              disp_rden,
  input  logic [ADDR_W-1:0] disp_rdidx,
  output logic [DATA_W-1:0] disp_rddata,
  output logic              bank_sel,
  output logic              init_busy,
  output logic              clear_overrun
);

`ifdef SPRLB_WRITE_MASK_EN
  localparam logic [ADDR_W-1:0] InitLast = ADDR_W'(VISIBLE - 1);
`else
  localparam logic [ADDR_W-1:0] InitLast = LAST_IDX;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              bank_sel_q, render_bank_q;
  logic              overrun_q, overrun_d;
  logic              clr_vld_q, clr_bank_q, disp_zero_q, render_zero_q;
  logic [ADDR_W-1:0] clr_idx_q;
  logic [DATA_W-1:0] disp_hold_q, disp_fresh;
  logic [DATA_W-1:0] bank_rdata [2];
  logic              init_act, sweep_we, render_we, rd_masked;

  assign init_act = (state_q == StInit);

`ifdef SPRLB_WRITE_MASK_EN
  assign sweep_we  = 1'b0;
  assign render_we = render_wren && (render_wridx < VIS_IDX);
  assign rd_masked = (render_rdidx >= VIS_IDX);
`else
  logic sweep_stall;
  // A pending read-clear on the display bank owns its write port this cycle.
  assign sweep_stall = clr_vld_q && (clr_bank_q != bank_sel_q);
  assign sweep_we    = (state_q == StSweep) && !sweep_stall;
  assign render_we   = render_wren;
  assign rd_masked   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    overrun_d = 1'b0;
    unique case (state_q)
      StInit: begin
        if (ptr_q == InitLast) begin
          state_d = StIdle;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      StIdle: ;
`ifndef SPRLB_WRITE_MASK_EN
      StSweep: begin
        if (!sweep_stall) begin
          if (ptr_q == LAST_IDX) state_d = StIdle;
          else                   ptr_d   = ptr_q + 1'b1;
        end
      end
`endif
      default: state_d = StInit;
    endcase
    if (line_render_start && !init_act) begin
`ifdef SPRLB_WRITE_MASK_EN
      state_d = StIdle;
`else
      state_d   = StSweep;
      ptr_d     = VIS_IDX;
      overrun_d = (state_q == StSweep);
`endif
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    localparam logic Id = 1'(g);
    logic              we;
    logic [ADDR_W-1:0] widx, ridx;
    logic [DATA_W-1:0] wdata;

    // Write port priority: init > read-clear > sweep > render.
    always_comb begin
      we    = 1'b0;
      widx  = ptr_q;
      wdata = '0;
      if (init_act) begin
        we = 1'b1;
      end else if (clr_vld_q && (clr_bank_q == Id)) begin
        we   = 1'b1;
        widx = clr_idx_q;
      end else if (sweep_we && (bank_sel_q != Id)) begin
        we = 1'b1;
      end else if (render_we && (bank_sel_q == Id)) begin
        we    = 1'b1;
        widx  = render_wridx;
        wdata = render_wrdata;
      end
    end

    assign ridx = (bank_sel_q == Id) ? render_rdidx : disp_rdidx;

    sprlb_bank u_bank (
      .clk_i     (clk),
      .rst_i     (rst),
      .rd_idx_i  (ridx),
      .rd_data_o (bank_rdata[g]),
      .wr_en_i   (we),
      .wr_idx_i  (widx),
      .wr_data_i (wdata)
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StInit;
      ptr_q         <= '0;
      bank_sel_q    <= 1'b0;
      render_bank_q <= 1'b0;
      overrun_q     <= 1'b0;
      clr_vld_q     <= 1'b0;
      clr_bank_q    <= 1'b0;
      clr_idx_q     <= '0;
      disp_zero_q   <= 1'b1;
      render_zero_q <= 1'b1;
      disp_hold_q   <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      overrun_q     <= overrun_d;
      render_bank_q <= bank_sel_q;
      render_zero_q <= init_act || rd_masked;
      if (line_render_start) bank_sel_q <= ~bank_sel_q;
      // Bank captured at read time is the one cleared next cycle, even across a swap.
      clr_vld_q  <= disp_rden;
      clr_idx_q  <= disp_rdidx;
      clr_bank_q <= ~bank_sel_q;
      if (disp_rden) disp_zero_q <= init_act;
      if (clr_vld_q) disp_hold_q <= disp_rddata;
    end
  end

  assign disp_fresh    = disp_zero_q ? '0 : bank_rdata[clr_bank_q];
  assign disp_rddata   = clr_vld_q ? disp_fresh : disp_hold_q;
  assign render_rddata = render_zero_q ? '0 : bank_rdata[render_bank_q];
  assign bank_sel      = bank_sel_q;
  assign init_busy     = init_act;
  assign clear_overrun = overrun_q;

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Bench for sprite_line_buffer: directed vector table, swap/overrun sequences and a
// randomized run against a per-bank array model. Honors SPRLB_WRITE_MASK_EN.
module tb_sprite_line_buffer;
  import sprlb_pkg::*;

  typedef struct packed {
    logic              sw;
    logic              we;
    logic [ADDR_W-1:0] wi;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ri;
    logic              de;
    logic [ADDR_W-1:0] di;
    logic [DATA_W-1:0] exp_r;
    logic [DATA_W-1:0] exp_d;
  } vec_t;

`ifdef SPRLB_WRITE_MASK_EN
  localparam int ExpInit = VISIBLE;
`else
  localparam int ExpInit = DEPTH;
`endif

  logic              clk;
  logic              rst = 1'b1;
  logic              line_render_start = 1'b0;
  logic [ADDR_W-1:0] render_rdidx = '0;
  logic [DATA_W-1:0] render_rddata;
  logic [ADDR_W-1:0] render_wridx = '0;
  logic [DATA_W-1:0] render_wrdata = '0;
  logic              render_wren = 1'b0;
  logic              disp_rden = 1'b0;
  logic [ADDR_W-1:0] disp_rdidx = '0;
  logic [DATA_W-1:0] disp_rddata;
  logic              bank_sel, init_busy, clear_overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int ovr_cnt = 0;

  vec_t              vt [9];
  logic [DATA_W-1:0] mdl [2][DEPTH];
  logic              mb, sw, we, mwe, de;
  logic [ADDR_W-1:0] wi, ri, di;
  logic [DATA_W-1:0] wd, rdv, exp_d;
  int                cyc, ovr0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (clear_overrun === 1'b1) ovr_cnt++;

  sprite_line_buffer dut (
    .clk               (clk),
    .rst               (rst),
    .line_render_start (line_render_start),
    .render_rdidx      (render_rdidx),
    .render_rddata     (render_rddata),
    .render_wridx      (render_wridx),
    .render_wrdata     (render_wrdata),
    .render_wren       (render_wren),
    .disp_rden         (disp_rden),
    .disp_rdidx        (disp_rdidx),
    .disp_rddata       (disp_rddata),
    .bank_sel          (bank_sel),
    .init_busy         (init_busy),
    .clear_overrun     (clear_overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs at a negedge; return at the next negedge.
  task automatic drive(input logic s, input logic w, input logic [ADDR_W-1:0] widx,
                       input logic [DATA_W-1:0] wdat, input logic [ADDR_W-1:0] ridx,
                       input logic d, input logic [ADDR_W-1:0] didx);
    line_render_start = s;
    render_wren       = w;
    render_wridx      = widx;
    render_wrdata     = wdat;
    render_rdidx      = ridx;
    disp_rden         = d;
    disp_rdidx        = didx;
    @(negedge clk);
    line_render_start = 1'b0;
    render_wren       = 1'b0;
    disp_rden         = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic swap_once();
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic wrt(input logic [ADDR_W-1:0] idx, input logic [DATA_W-1:0] d);
    drive(1'b0, 1'b1, idx, d, '0, 1'b0, '0);
  endtask

  task automatic rrd(input logic [ADDR_W-1:0] idx);
    drive(1'b0, 1'b0, '0, '0, idx, 1'b0, '0);
  endtask

  task automatic do_init(output int n);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (init_busy === 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    //          sw    we    wi       wd        ri       de    di       exp_r     exp_d
    vt[0] = '{1'b0, 1'b1, 10'd100, 16'h1305, 10'd100, 1'b0, 10'd0,   16'h1305, 16'h0000};
    vt[1] = '{1'b0, 1'b1, 10'd7,   16'hA0FF, 10'd7,   1'b0, 10'd0,   16'hA0FF, 16'h0000};
    vt[2] = '{1'b0, 1'b0, 10'd0,   16'h0000, 10'd100, 1'b0, 10'd0,   16'h1305, 16'h0000};
    vt[3] = '{1'b1, 1'b0, 10'd0,   16'h0000, 10'd7,   1'b0, 10'd0,   16'hA0FF, 16'h0000};
    vt[4] = '{1'b0, 1'b0, 10'd0,   16'h0000, 10'd100, 1'b1, 10'd100, 16'h0000, 16'h1305};
    vt[5] = '{1'b0, 1'b0, 10'd0,   16'h0000, 10'd0,   1'b1, 10'd100, 16'h0000, 16'h0000};
    vt[6] = '{1'b0, 1'b0, 10'd0,   16'h0000, 10'd5,   1'b1, 10'd7,   16'h0000, 16'hA0FF};
    vt[7] = '{1'b0, 1'b0, 10'd0,   16'h0000, 10'd5,   1'b0, 10'd0,   16'h0000, 16'hA0FF};
    vt[8] = '{1'b0, 1'b0, 10'd0,   16'h0000, 10'd7,   1'b1, 10'd7,   16'h0000, 16'h0000};

    @(negedge clk);
    @(negedge clk);
    check("rst_bank_sel", bank_sel, 0);
    check("rst_init_busy", init_busy, 1);
    check("rst_clear_overrun", clear_overrun, 0);
    check("rst_render_rddata", render_rddata, 0);
    check("rst_disp_rddata", disp_rddata, 0);

    do_init(cyc);
    check("init_cycles", cyc, ExpInit);

    for (int i = 0; i < 9; i++) begin
      drive(vt[i].sw, vt[i].we, vt[i].wi, vt[i].wd, vt[i].ri, vt[i].de, vt[i].di);
      check($sformatf("vec%0d_render", i), render_rddata, vt[i].exp_r);
      check($sformatf("vec%0d_disp", i), disp_rddata, vt[i].exp_d);
    end

`ifndef SPRLB_WRITE_MASK_EN
    idle(420);
    check("no_overrun_table", ovr_cnt, 0);
    check("bank_sel_table", bank_sel, 1);

    // Tail at 900 is swept after exactly 384 idle cycles; a swap right then is clean.
    wrt(10'd900, 16'h0042);
    swap_once();
    idle(384);
    swap_once();
    rrd(10'd900);
    check("swept_900", render_rddata, 16'h0000);
    idle(4);
    check("no_overrun_min_sweep", ovr_cnt, 0);

    // Second swap 100 cycles in: overrun pulse, old tail kept, sweep restarts at 640.
    idle(400);
    ovr0 = ovr_cnt;
    wrt(10'd1000, 16'h1234);
    wrt(10'd650, 16'h5678);
    swap_once();
    idle(1);
    wrt(10'd1000, 16'h9ABC);
    wrt(10'd700, 16'hDEF0);
    idle(96);
    swap_once();
    check("overrun_pulse", clear_overrun, 1);
    idle(1);
    check("overrun_width", clear_overrun, 0);
    idle(400);
    check("overrun_count", ovr_cnt - ovr0, 1);
    rrd(10'd1000);
    check("old_tail_kept", render_rddata, 16'h1234);
    rrd(10'd650);
    check("old_head_swept", render_rddata, 16'h0000);
    swap_once();
    idle(1);
    rrd(10'd1000);
    check("restart_1000", render_rddata, 16'h0000);
    rrd(10'd700);
    check("restart_700", render_rddata, 16'h0000);
`else
    drive(1'b0, 1'b1, 10'd700, 16'h00FF, 10'd700, 1'b0, 10'd0);
    check("mask_bypass_700", render_rddata, 16'h0000);
    rrd(10'd700);
    check("mask_read_700", render_rddata, 16'h0000);
    swap_once();
    idle(1);
    swap_once();
    idle(4);
    check("mask_no_overrun", ovr_cnt, 0);
`endif

    // Fresh start for the randomized run so the model begins from all-zero banks.
    do_init(cyc);
    check("reinit_cycles", cyc, ExpInit);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, '0, '0, ADDR_W'(i), 1'b1, ADDR_W'(i));
      if (i % 64 == 0) check("clear_render", render_rddata, 16'h0000);
      check("clear_disp", disp_rddata, 16'h0000);
    end

    ovr0 = ovr_cnt;
    mb    = 1'b0;
    exp_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mdl[0][i] = '0;
      mdl[1][i] = '0;
    end
    for (int l = 0; l < 16; l++) begin
      for (int c = 0; c < 1100; c++) begin
        sw  = (c == 0);
        we  = (c != 1) && ($urandom_range(0, 2) == 0);
        wi  = ADDR_W'($urandom_range(0, DEPTH - 1));
        wd  = DATA_W'($urandom);
        ri  = ADDR_W'($urandom_range(0, DEPTH - 1));
        de  = ($urandom_range(0, 1) == 1);
        di  = ADDR_W'($urandom_range(0, VISIBLE - 1));
        mwe = we;
`ifdef SPRLB_WRITE_MASK_EN
        if (wi >= VIS_IDX) mwe = 1'b0;
`endif
        rdv = mdl[mb][ri];
        if (mwe && (wi == ri)) rdv = wd;
`ifdef SPRLB_WRITE_MASK_EN
        if (ri >= VIS_IDX) rdv = '0;
`endif
        if (de) begin
          exp_d        = mdl[~mb][di];
          mdl[~mb][di] = '0;
        end
        if (mwe) mdl[mb][wi] = wd;
        if (sw) begin
          mb = ~mb;
          for (int i = VISIBLE; i < DEPTH; i++) mdl[~mb][i] = '0;
        end
        drive(sw, we, wi, wd, ri, de, di);
        check("rand_render", render_rddata, rdv);
        check("rand_disp", disp_rddata, exp_d);
        if (c == 0) check("rand_bank_sel", bank_sel, mb);
      end
    end
    check("rand_no_overrun", ovr_cnt - ovr0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
